amstrad_audio_mixer: RTL

- Parametrised stereo mixer replacing the fixed 3-channel PSG summing network on the motherboard.
- Accepts NCH unsigned channels (PSG A/B/C plus expansion PSGs/sample DAC), applies per-channel left/right gain and sums with a time-multiplexed MAC, one channel per clk.
- Saturates to OW bits and presents a registered stereo sample with a valid strobe at each sample enable.
- Adds a mono mode, a mute input, and clip and overrun reporting.

---
 rtl/amstrad_audio_pkg.sv | 30 +++
 rtl/amstrad_mix_sat.sv | 40 ++++
 rtl/amstrad_audio_mixer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/amstrad_audio_pkg.sv
// Shared types and helpers for the stereo audio mixer.
//   state_e   : mixer sequencing states
//   aw_calc   : accumulator width for a given channel count / sample / gain width
//   gain_mult : gain field -> multiplier (0 stays 0, otherwise g+1)
//   sat_u     : unsigned saturation to ow bits, returns {clip, value}
package amstrad_audio_pkg;

  typedef enum logic [1:0] {IDLE, ACC, SCALE} state_e;

  // Working width of the saturation helper; OW must stay below this.
  localparam int SATW = 32;

  // One extra bit over IW+GW covers the g+1 multiplier, clog2(nch) covers the sum.
  function automatic int aw_calc(input int nch, input int iw, input int gw);
    return iw + gw + 1 + $clog2(nch);
  endfunction

  // g=0 mutes the channel; otherwise g+1 so the top code is exactly 2^GW (unity).
  function automatic logic [16:0] gain_mult(input logic [15:0] g);
    return (g == 16'd0) ? 17'd0 : ({1'b0, g} + 17'd1);
  endfunction

  function automatic logic [SATW:0] sat_u(input logic [SATW-1:0] v, input int ow);
    logic [SATW-1:0] maxv;
    maxv = (SATW'(1) << ow) - SATW'(1);
    if (v > maxv) return {1'b1, maxv};
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/amstrad_mix_sat.sv
// Combinational output stage: drop the gain fraction bits, optionally average
// L/R for mono, then saturate each side to OW bits with a clip flag.
//   acc_l/acc_r : final accumulator values
//   mono        : 1 = both sides carry the L/R average
//   s_l/s_r     : saturated samples, clip_l/clip_r : saturation indicators
module amstrad_mix_sat
  import amstrad_audio_pkg::*;
#(
  parameter int AW = 16,
  parameter int GW = 4,
  parameter int OW = 10
) (
  input  logic [AW-1:0] acc_l,
  input  logic [AW-1:0] acc_r,
  input  logic          mono,
  output logic [OW-1:0] s_l,
  output logic [OW-1:0] s_r,
  output logic          clip_l,
  output logic          clip_r
);

  logic [AW-1:0]   sh_l, sh_r, v_l, v_r;
  logic [AW:0]     avg;
  logic [SATW:0]   r_l, r_r;

  assign sh_l = acc_l >> GW;
  assign sh_r = acc_r >> GW;
  // Sum one bit wider so the average never wraps; it then fits back in AW bits.
  assign avg  = ({1'b0, sh_l} + {1'b0, sh_r}) >> 1;
  assign v_l  = mono ? AW'(avg) : sh_l;
  assign v_r  = mono ? AW'(avg) : sh_r;

  assign r_l    = sat_u(SATW'(v_l), OW);
  assign r_r    = sat_u(SATW'(v_r), OW);
  assign s_l    = OW'(r_l);
  assign s_r    = OW'(r_r);
  assign clip_l = r_l[SATW];
  assign clip_r = r_r[SATW];

endmodule

// File: rtl/amstrad_audio_mixer.sv
// Parametrised stereo mixer. On ce the channel samples and gains are
// snapshotted, then one channel per clk is multiplied and accumulated into
// left/right sums; a final cycle scales, saturates and registers the result.
//   clk, reset        : clock, synchronous active-high reset
//   ce                : starts a mix pass (ignored and flagged while busy)
//   ch_in/gain_l/_r   : packed channel samples and per-channel gains
//   mono, mute        : output modes
//   out_l/out_r/valid : registered stereo sample and its one-cycle strobe
//   busy, clip_l/_r   : pass in progress, saturation in last sample
//   overrun           : sticky, ce arrived while busy
module amstrad_audio_mixer
  import amstrad_audio_pkg::*;
#(
  parameter int NCH = 3,
  parameter int IW  = 8,
  parameter int GW  = 4,
  parameter int OW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [NCH*IW-1:0] ch_in,
  input  logic [NCH*GW-1:0] gain_l,
  input  logic [NCH*GW-1:0] gain_r,
  input  logic              mono,
  input  logic              mute,
  output logic [OW-1:0]     out_l,
  output logic [OW-1:0]     out_r,
  output logic              valid,
  output logic              busy,
  output logic              clip_l,
  output logic              clip_r,
  output logic              overrun
);

  localparam int AW    = aw_calc(NCH, IW, GW);
  localparam int IDXW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NSLOT = 1 << IDXW;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [AW-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [NCH*IW-1:0] ch_q, ch_d;
  logic [NCH*GW-1:0] gl_q, gl_d, gr_q, gr_d;
  logic [OW-1:0]     out_l_q, out_l_d, out_r_q, out_r_d;
  logic              valid_q, valid_d, busy_q, busy_d;
  logic              clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic              overrun_q, overrun_d;

  // Snapshot unpacked into power-of-two arrays so idx can index directly;
  // slots past NCH are never selected and read as zero.
  logic [IW-1:0] ch_a [NSLOT];
  logic [GW-1:0] gl_a [NSLOT];
  logic [GW-1:0] gr_a [NSLOT];

  for (genvar k = 0; k < NSLOT; k++) begin : g_unpack
    if (k < NCH) begin : g_ch
      assign ch_a[k] = ch_q[k*IW +: IW];
      assign gl_a[k] = gl_q[k*GW +: GW];
      assign gr_a[k] = gr_q[k*GW +: GW];
    end else begin : g_pad
      assign ch_a[k] = '0;
      assign gl_a[k] = '0;
      assign gr_a[k] = '0;
    end
  end

  logic [AW-1:0] smp, m_l, m_r;
  assign smp = AW'(ch_a[idx_q]);
  assign m_l = AW'(gain_mult(16'(gl_a[idx_q])));
  assign m_r = AW'(gain_mult(16'(gr_a[idx_q])));

  logic [OW-1:0] s_l, s_r;
  logic          sc_l, sc_r;

  amstrad_mix_sat #(.AW(AW), .GW(GW), .OW(OW)) u_sat (
    .acc_l  (acc_l_q),
    .acc_r  (acc_r_q),
    .mono   (mono),
    .s_l    (s_l),
    .s_r    (s_r),
    .clip_l (sc_l),
    .clip_r (sc_r)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    ch_d      = ch_q;
    gl_d      = gl_q;
    gr_d      = gr_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    clip_l_d  = clip_l_q;
    clip_r_d  = clip_r_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    // Any ce outside IDLE (including the SCALE cycle) is dropped and flagged.
    overrun_d = overrun_q | (ce & (state_q != IDLE));
    case (state_q)
      IDLE: if (ce) begin
        ch_d    = ch_in;
        gl_d    = gain_l;
        gr_d    = gain_r;
        acc_l_d = '0;
        acc_r_d = '0;
        idx_d   = '0;
        busy_d  = 1'b1;
        state_d = ACC;
      end
      ACC: begin
        acc_l_d = acc_l_q + smp * m_l;
        acc_r_d = acc_r_q + smp * m_r;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDXW'(NCH-1)) state_d = SCALE;
      end
      SCALE: begin
        // Mute zeroes the samples but clip still reports the true mix.
        out_l_d  = mute ? '0 : s_l;
        out_r_d  = mute ? '0 : s_r;
        clip_l_d = sc_l;
        clip_r_d = sc_r;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      ch_q      <= '0;
      gl_q      <= '0;
      gr_q      <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      ch_q      <= ch_d;
      gl_q      <= gl_d;
      gr_q      <= gr_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      clip_l_q  <= clip_l_d;
      clip_r_q  <= clip_r_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_l   = out_l_q;
  assign out_r   = out_r_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign clip_l  = clip_l_q;
  assign clip_r  = clip_r_q;
  assign overrun = overrun_q;

endmodule
